// File: rtl/register_file_if.sv
// Bus bundle for register_file: two combinational read ports, the write-back port
// and the debug dump stream.
interface register_file_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5
);
   logic [NB_ADDR-1:0] i_rs1_addr;
   logic [NB_ADDR-1:0] i_rs2_addr;
   logic [NB_DATA-1:0] o_rs1_data;
   logic [NB_DATA-1:0] o_rs2_data;
   logic               i_wb_RegWrite;
   logic [NB_ADDR-1:0] i_wb_rd;
   logic [NB_DATA-1:0] i_wb_data;
   logic               i_dump_start;
   logic               i_dump_ready;
   logic               o_dump_valid;
   logic [NB_DATA-1:0] o_dump_data;
   logic [NB_ADDR-1:0] o_dump_addr;
   logic               o_dump_last;
   logic               o_dump_busy;
   logic               o_dump_done;

   modport master (
      output i_rs1_addr, i_rs2_addr, i_wb_RegWrite, i_wb_rd, i_wb_data,
             i_dump_start, i_dump_ready,
      input  o_rs1_data, o_rs2_data, o_dump_valid, o_dump_data, o_dump_addr,
             o_dump_last, o_dump_busy, o_dump_done
   );

   modport slave (
      input  i_rs1_addr, i_rs2_addr, i_wb_RegWrite, i_wb_rd, i_wb_data,
             i_dump_start, i_dump_ready,
      output o_rs1_data, o_rs2_data, o_dump_valid, o_dump_data, o_dump_addr,
             o_dump_last, o_dump_busy, o_dump_done
   );
endinterface

// File: rtl/register_file.sv
// Register file with x0 hardwired to zero, write-first bypass on both read ports,
// and a ready/valid debug dump that streams every register in index order.
//
// state | meaning
// IDLE  | no dump in progress, waiting for i_dump_start
// DUMP  | presenting reg[idx], advancing on each accepted word
// DONE  | single-cycle completion pulse after the last word
module register_file #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5
) (
   input logic            i_clk,
   input logic            i_rst,
   register_file_if.slave bus
);
   localparam int NREG = 2 ** NB_ADDR;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DUMP = 2'd1,
      S_DONE = 2'd2
   } dump_state_t;

   logic [NB_DATA-1:0] regs [NREG];
   dump_state_t        state_q, state_d;
   logic [NB_ADDR-1:0] idx_q, idx_d;
   logic               wr_en;

   assign wr_en = bus.i_wb_RegWrite && (bus.i_wb_rd != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.i_wb_rd] <= bus.i_wb_data;
      end
   end

   // Write-back data wins over the stored value so ID sees the result the same cycle.
   always_comb begin
      bus.o_rs1_data = '0;
      bus.o_rs2_data = '0;
      if (wr_en && (bus.i_wb_rd == bus.i_rs1_addr)) begin
         bus.o_rs1_data = bus.i_wb_data;
      end else if (bus.i_rs1_addr != '0) begin
         bus.o_rs1_data = regs[bus.i_rs1_addr];
      end
      if (wr_en && (bus.i_wb_rd == bus.i_rs2_addr)) begin
         bus.o_rs2_data = bus.i_wb_data;
      end else if (bus.i_rs2_addr != '0) begin
         bus.o_rs2_data = regs[bus.i_rs2_addr];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_dump_start) begin
               state_d = S_DUMP;
               idx_d   = '0;
            end
         end
         S_DUMP: begin
            // The last index leaves idx at its final value rather than wrapping.
            if (bus.i_dump_ready) begin
               if (idx_q == '1) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.o_dump_valid = (state_q == S_DUMP);
      bus.o_dump_last  = (state_q == S_DUMP) && (idx_q == '1);
      bus.o_dump_busy  = (state_q != S_IDLE);
      bus.o_dump_done  = (state_q == S_DONE);
      bus.o_dump_addr  = '0;
      bus.o_dump_data  = '0;
      if (state_q == S_DUMP) begin
         bus.o_dump_addr = idx_q;
         if (idx_q != '0) begin
            bus.o_dump_data = regs[idx_q];
         end
      end
   end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases plus randomized traffic
// compared against an array model of the register contents.
module tb_register_file;
   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 5;

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   register_file_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

   register_file #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model [32];
   bit          fin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_read(input int a, input bit we, input int rd,
                                            input logic [31:0] d);
      if (we && rd != 0 && rd == a) return d;
      if (a == 0) return 32'h0;
      return model[a];
   endfunction

   task automatic wr_cycle(input int rd, input logic [31:0] d);
      @(negedge i_clk);
      bus.i_wb_RegWrite = 1'b1;
      bus.i_wb_rd       = rd[NB_ADDR-1:0];
      bus.i_wb_data     = d;
      @(posedge i_clk);
      if (rd != 0) model[rd] = d;
      #1 bus.i_wb_RegWrite = 1'b0;
   endtask

   task automatic read_chk(input string tag, input int a1, input int a2);
      @(negedge i_clk);
      bus.i_rs1_addr = a1[NB_ADDR-1:0];
      bus.i_rs2_addr = a2[NB_ADDR-1:0];
      #1;
      chk({tag, "_rs1"}, bus.o_rs1_data, ref_read(a1, 1'b0, 0, 32'h0));
      chk({tag, "_rs2"}, bus.o_rs2_data, ref_read(a2, 1'b0, 0, 32'h0));
   endtask

   task automatic dump_idle_chk(input string tag);
      chk({tag, "_valid"}, {31'h0, bus.o_dump_valid}, 32'h0);
      chk({tag, "_busy"},  {31'h0, bus.o_dump_busy},  32'h0);
      chk({tag, "_last"},  {31'h0, bus.o_dump_last},  32'h0);
      chk({tag, "_done"},  {31'h0, bus.o_dump_done},  32'h0);
      chk({tag, "_addr"},  {27'h0, bus.o_dump_addr},  32'h0);
      chk({tag, "_data"},  bus.o_dump_data,           32'h0);
   endtask

   // Runs one dump; stops early (before the edge) once the expected index reaches stop_idx.
   task automatic dump_run(input bit toggle, input bit rand_wr, input int stop_idx,
                           output bit finished);
      int          idx;
      bit          rdy;
      bit          we;
      int          rd;
      logic [31:0] d;
      idx      = 0;
      finished = 1'b0;
      @(negedge i_clk);
      bus.i_dump_start = 1'b1;
      bus.i_dump_ready = 1'b0;
      @(posedge i_clk);
      #1 bus.i_dump_start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge i_clk);
         rdy = toggle ? (c % 2 == 0) : 1'b1;
         we  = rand_wr && ($urandom_range(0, 2) == 0);
         rd  = $urandom_range(0, 31);
         if (we && $urandom_range(0, 1) == 1) rd = idx;
         d   = $urandom;
         bus.i_dump_ready  = rdy;
         bus.i_dump_start  = toggle && (c % 7 == 3);
         bus.i_wb_RegWrite = we;
         bus.i_wb_rd       = rd[NB_ADDR-1:0];
         bus.i_wb_data     = d;
         #1;
         chk("dump_valid", {31'h0, bus.o_dump_valid}, 32'h1);
         chk("dump_addr",  {27'h0, bus.o_dump_addr},  idx);
         chk("dump_data",  bus.o_dump_data,           model[idx]);
         chk("dump_last",  {31'h0, bus.o_dump_last},  (idx == 31) ? 32'h1 : 32'h0);
         chk("dump_busy",  {31'h0, bus.o_dump_busy},  32'h1);
         chk("dump_done",  {31'h0, bus.o_dump_done},  32'h0);
         if (idx == stop_idx) begin
            bus.i_wb_RegWrite = 1'b0;
            bus.i_dump_start  = 1'b0;
            return;
         end
         @(posedge i_clk);
         if (we && rd != 0) model[rd] = d;
         #1;
         bus.i_wb_RegWrite = 1'b0;
         bus.i_dump_start  = 1'b0;
         if (rdy) begin
            if (idx == 31) begin
               finished = 1'b1;
               break;
            end
            idx++;
         end
      end
      chk("dump_finished", {31'h0, finished}, 32'h1);
      if (finished) begin
         chk("done_pulse", {31'h0, bus.o_dump_done},  32'h1);
         chk("done_busy",  {31'h0, bus.o_dump_busy},  32'h1);
         chk("done_valid", {31'h0, bus.o_dump_valid}, 32'h0);
         chk("done_last",  {31'h0, bus.o_dump_last},  32'h0);
         @(posedge i_clk);
         #1;
         chk("after_done", {31'h0, bus.o_dump_done}, 32'h0);
         chk("after_busy", {31'h0, bus.o_dump_busy}, 32'h0);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      i_rst             = 1'b1;
      bus.i_rs1_addr    = '0;
      bus.i_rs2_addr    = '0;
      bus.i_wb_RegWrite = 1'b0;
      bus.i_wb_rd       = '0;
      bus.i_wb_data     = '0;
      bus.i_dump_start  = 1'b0;
      bus.i_dump_ready  = 1'b0;

      // Reset state
      #12;
      dump_idle_chk("rst");
      bus.i_rs1_addr = 5'd9;
      bus.i_rs2_addr = 5'd31;
      #1;
      chk("rst_rs1", bus.o_rs1_data, 32'h0);
      chk("rst_rs2", bus.o_rs2_data, 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Directed write/read cases
      wr_cycle(5, 32'hDEADBEEF);
      read_chk("x5_x0", 5, 0);
      chk("x5_const", bus.o_rs1_data, 32'hDEADBEEF);
      wr_cycle(0, 32'h1234);
      read_chk("x0_write", 0, 0);
      chk("x0_const", bus.o_rs1_data, 32'h0);

      // Same-cycle bypass to both ports
      @(negedge i_clk);
      bus.i_wb_RegWrite = 1'b1;
      bus.i_wb_rd       = 5'd7;
      bus.i_wb_data     = 32'hA5A5A5A5;
      bus.i_rs1_addr    = 5'd7;
      bus.i_rs2_addr    = 5'd7;
      #1;
      chk("byp_rs1_pre", bus.o_rs1_data, 32'hA5A5A5A5);
      chk("byp_rs2_pre", bus.o_rs2_data, 32'hA5A5A5A5);
      @(posedge i_clk);
      model[7] = 32'hA5A5A5A5;
      #1 bus.i_wb_RegWrite = 1'b0;
      #1;
      chk("byp_rs1_post", bus.o_rs1_data, 32'hA5A5A5A5);
      chk("byp_rs2_post", bus.o_rs2_data, 32'hA5A5A5A5);

      // Randomized traffic, biased towards bypass collisions
      for (int n = 0; n < 150; n++) begin
         bit          we;
         int          rd, a1, a2;
         logic [31:0] d;
         we = $urandom_range(0, 1);
         rd = $urandom_range(0, 31);
         d  = $urandom;
         a1 = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, 31);
         a2 = ($urandom_range(0, 3) == 0) ? rd : $urandom_range(0, 31);
         @(negedge i_clk);
         bus.i_wb_RegWrite = we;
         bus.i_wb_rd       = rd[NB_ADDR-1:0];
         bus.i_wb_data     = d;
         bus.i_rs1_addr    = a1[NB_ADDR-1:0];
         bus.i_rs2_addr    = a2[NB_ADDR-1:0];
         #1;
         chk("rnd_rs1", bus.o_rs1_data, ref_read(a1, we, rd, d));
         chk("rnd_rs2", bus.o_rs2_data, ref_read(a2, we, rd, d));
         @(posedge i_clk);
         if (we && rd != 0) model[rd] = d;
         #1 bus.i_wb_RegWrite = 1'b0;
      end

      // Full dump with ready held high over a known pattern
      for (int n = 1; n < 32; n++) wr_cycle(n, n * 16);
      dump_run(1'b0, 1'b0, -1, fin);

      // Dump with ready toggling, start re-pulsed and writes landing mid-dump
      dump_run(1'b1, 1'b1, -1, fin);

      // Asynchronous reset in the middle of a dump
      dump_run(1'b0, 1'b0, 12, fin);
      #2 i_rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      dump_idle_chk("midrst");
      bus.i_rs1_addr = 5'd7;
      bus.i_rs2_addr = 5'd16;
      #1;
      chk("midrst_rs1", bus.o_rs1_data, 32'h0);
      chk("midrst_rs2", bus.o_rs2_data, 32'h0);
      @(negedge i_clk);
      i_rst = 1'b0;
      read_chk("post_rst", 12, 31);
      dump_run(1'b0, 1'b0, -1, fin);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
